// File: rtl/pcm_frame_packer_if.sv
// Serialised PCM beat stream: one channel sample per beat, valid/ready handshake.
interface pcm_frame_packer_if #(
    parameter int NCH = 8,
    parameter int W   = 17
);
    localparam int CW = $clog2(NCH);

    logic [W-1:0]  m_data;
    logic [CW-1:0] m_chan;
    logic          m_first;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;

    modport master (
        output m_data, m_chan, m_first, m_last, m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data, m_chan, m_first, m_last, m_valid,
        output m_ready
    );
endinterface

// File: rtl/pcm_frame_packer.sv
// Snapshots NCH CIC outputs per decimation strobe and streams them one channel
// per beat, with start-up frame skipping, a one-frame pending buffer and drop tracking.
module pcm_frame_packer #(
    parameter int NCH         = 8,
    parameter int W           = 17,
    parameter int SKIP_FRAMES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_stb,
    input  logic [NCH*W-1:0]     s_data,
    pcm_frame_packer_if.master   m,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic [7:0]           drop_cnt,
    output logic [15:0]          frame_cnt
);
    localparam int            CW       = $clog2(NCH);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    skip_reg, skip_next;
    logic [CW-1:0] idx_reg, idx_next, idx_inc;
    logic [W-1:0]  act_reg [NCH];
    logic [W-1:0]  act_next [NCH];
    logic [W-1:0]  pend_reg [NCH];
    logic [W-1:0]  pend_next [NCH];
    logic          pend_full_reg, pend_full_next;
    logic [W-1:0]  data_reg, data_next;
    logic          first_reg, first_next;
    logic          last_reg, last_next;
    logic          ovf_reg, ovf_next;
    logic [7:0]    drop_cnt_reg, drop_cnt_next;
    logic [15:0]   frame_cnt_reg, frame_cnt_next;

    logic [W-1:0]  s_ch [NCH];
    logic          stb_eff, xfer, last_xfer, drop;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign s_ch[gi] = s_data[gi*W +: W];
        end
    endgenerate

    assign stb_eff   = dec_stb && (skip_reg == 4'd0);
    assign xfer      = (state_reg == SEND) && m.m_ready;
    assign last_xfer = xfer && (idx_reg == LAST_IDX);
    assign idx_inc   = idx_reg + CW'(1);

    always_comb begin
        state_next     = state_reg;
        skip_next      = skip_reg;
        idx_next       = idx_reg;
        act_next       = act_reg;
        pend_next      = pend_reg;
        pend_full_next = pend_full_reg;
        data_next      = data_reg;
        ovf_next       = ovf_reg;
        drop_cnt_next  = drop_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        drop           = 1'b0;

        if (dec_stb && (skip_reg != 4'd0))
            skip_next = skip_reg - 4'd1;

        case (state_reg)
            IDLE: begin
                if (stb_eff) begin
                    act_next   = s_ch;
                    idx_next   = '0;
                    data_next  = s_ch[0];
                    state_next = SEND;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                    if (pend_full_reg) begin
                        // Pending frame follows with no bubble; a coincident strobe refills pending.
                        act_next  = pend_reg;
                        idx_next  = '0;
                        data_next = pend_reg[0];
                        if (stb_eff)
                            pend_next = s_ch;
                        else
                            pend_full_next = 1'b0;
                    end else if (stb_eff) begin
                        act_next  = s_ch;
                        idx_next  = '0;
                        data_next = s_ch[0];
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_next  = idx_inc;
                        data_next = act_reg[idx_inc];
                    end
                    if (stb_eff) begin
                        if (!pend_full_reg) begin
                            pend_next      = s_ch;
                            pend_full_next = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A drop coinciding with a clear leaves exactly that one drop recorded.
        if (drop) begin
            ovf_next = 1'b1;
            if (ovf_clr)
                drop_cnt_next = 8'd1;
            else if (drop_cnt_reg != 8'hFF)
                drop_cnt_next = drop_cnt_reg + 8'd1;
        end else if (ovf_clr) begin
            ovf_next      = 1'b0;
            drop_cnt_next = 8'd0;
        end

        first_next = (state_next == SEND) && (idx_next == '0);
        last_next  = (state_next == SEND) && (idx_next == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            skip_reg      <= 4'(SKIP_FRAMES);
            idx_reg       <= '0;
            act_reg       <= '{default: '0};
            pend_reg      <= '{default: '0};
            pend_full_reg <= 1'b0;
            data_reg      <= '0;
            first_reg     <= 1'b0;
            last_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            drop_cnt_reg  <= 8'd0;
            frame_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            skip_reg      <= skip_next;
            idx_reg       <= idx_next;
            act_reg       <= act_next;
            pend_reg      <= pend_next;
            pend_full_reg <= pend_full_next;
            data_reg      <= data_next;
            first_reg     <= first_next;
            last_reg      <= last_next;
            ovf_reg       <= ovf_next;
            drop_cnt_reg  <= drop_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign m.m_valid = (state_reg == SEND);
    assign m.m_data  = data_reg;
    assign m.m_chan  = idx_reg;
    assign m.m_first = first_reg;
    assign m.m_last  = last_reg;
    assign ovf       = ovf_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_pcm_frame_packer.sv
// Randomised and directed bench for pcm_frame_packer against a beat-queue reference model.
module tb_pcm_frame_packer;
    localparam int NCH  = 4;
    localparam int W    = 17;
    localparam int SKIP = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_stb;
    logic [NCH*W-1:0] s_data;
    logic             ovf;
    logic             ovf_clr;
    logic [7:0]       drop_cnt;
    logic [15:0]      frame_cnt;

    pcm_frame_packer_if #(.NCH(NCH), .W(W)) sif ();

    pcm_frame_packer #(.NCH(NCH), .W(W), .SKIP_FRAMES(SKIP)) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_stb   (dec_stb),
        .s_data    (s_data),
        .m         (sif),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .drop_cnt  (drop_cnt),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           ch;
    } beat_t;

    // Reference model: the outstanding beats, in emission order.
    beat_t q[$];
    int    mdl_skip;
    bit    mdl_ovf;
    int    mdl_drop;
    int    mdl_fc;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*W-1:0] rnd_frame();
        logic [NCH*W-1:0] f;
        for (int k = 0; k < NCH; k++) f[k*W +: W] = W'($urandom);
        return f;
    endfunction

    task automatic model_reset();
        q.delete();
        mdl_skip = SKIP;
        mdl_ovf  = 1'b0;
        mdl_drop = 0;
        mdl_fc   = 0;
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(sif.m_valid), 32'(q.size() != 0));
        if (q.size() != 0 && sif.m_valid) begin
            chk("m_data",  32'(sif.m_data),  32'(q[0].d));
            chk("m_chan",  32'(sif.m_chan),  32'(q[0].ch));
            chk("m_first", 32'(sif.m_first), 32'(q[0].ch == 0));
            chk("m_last",  32'(sif.m_last),  32'(q[0].ch == NCH - 1));
        end
        chk("ovf",       32'(ovf),       32'(mdl_ovf));
        chk("drop_cnt",  32'(drop_cnt),  32'(mdl_drop));
        chk("frame_cnt", 32'(frame_cnt), 32'(mdl_fc & 16'hFFFF));
    endtask

    // Applies the inputs now being driven to the model for the coming clock edge.
    task automatic model_update();
        bit xfer;
        bit last_x;
        bit drop;
        int held;
        xfer   = (q.size() != 0) && sif.m_ready;
        last_x = xfer && (q[0].ch == NCH - 1);
        held   = (q.size() + NCH - 1) / NCH;
        drop   = 1'b0;
        if (xfer) begin
            $display("beat ch=%0d data=%05h first=%0d last=%0d", q[0].ch, q[0].d,
                     q[0].ch == 0, q[0].ch == NCH - 1);
            void'(q.pop_front());
            if (last_x) mdl_fc++;
        end
        if (dec_stb) begin
            if (mdl_skip > 0) mdl_skip--;
            else if (held - int'(last_x) < 2) begin
                for (int k = 0; k < NCH; k++) q.push_back('{d: s_data[k*W +: W], ch: k});
            end else drop = 1'b1;
        end
        if (drop) begin
            mdl_ovf  = 1'b1;
            mdl_drop = ovf_clr ? 1 : (mdl_drop < 255 ? mdl_drop + 1 : 255);
        end else if (ovf_clr) begin
            mdl_ovf  = 1'b0;
            mdl_drop = 0;
        end
    endtask

    task automatic step(input logic stb, input logic [NCH*W-1:0] d, input logic rdy, input logic clr);
        check_outputs();
        dec_stb     = stb;
        s_data      = d;
        sif.m_ready = rdy;
        ovf_clr     = clr;
        if (!rst) model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, rnd_frame(), rdy, 1'b0);
    endtask

    task automatic wait_q(input int target, input string tag);
        int budget;
        budget = 0;
        while (q.size() != target && budget < 30) begin
            step(1'b0, rnd_frame(), 1'b1, 1'b0);
            budget++;
        end
        chk(tag, 32'(q.size()), 32'(target));
    endtask

    logic [NCH*W-1:0] f1;
    int fc_before;
    int pct;

    initial begin
        rst = 1'b1; dec_stb = 1'b0; s_data = '0; ovf_clr = 1'b0; sif.m_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(sif.m_valid), 0);
        chk("rst_data",  32'(sif.m_data), 0);
        chk("rst_first", 32'(sif.m_first), 0);
        chk("rst_last",  32'(sif.m_last), 0);
        chk("rst_ovf",   32'(ovf), 0);
        chk("rst_fcnt",  32'(frame_cnt), 0);
        rst = 1'b0;

        // Skip phase, then the reference frame.
        f1 = {17'h1FFFF, 17'h00033, 17'h00022, 17'h00011};
        for (int s = 0; s < 4; s++) begin
            step(1'b1, f1, 1'b1, 1'b0);
            idle(7, 1'b1);
        end
        chk("t1_frame_cnt", 32'(frame_cnt), 1);

        // Stall mid-frame, then alternate ready.
        step(1'b1, rnd_frame(), 1'b1, 1'b0);
        step(1'b0, rnd_frame(), 1'b1, 1'b0);
        idle(5, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, rnd_frame(), 1'(i % 2), 1'b0);
        idle(6, 1'b1);

        // Double buffer under back-pressure.
        step(1'b1, rnd_frame(), 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, rnd_frame(), 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(10, 1'b1);
        chk("t3_ovf", 32'(ovf), 0);

        // Overflow, then a clear colliding with a further drop.
        step(1'b1, rnd_frame(), 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b1, rnd_frame(), 1'b0, 1'b0);
        step(1'b1, rnd_frame(), 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b1, rnd_frame(), 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_drop", 32'(drop_cnt), 2);
        step(1'b1, rnd_frame(), 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("t4_clr_ovf", 32'(ovf), 1);
        chk("t4_clr_drop", 32'(drop_cnt), 1);
        idle(12, 1'b1);
        step(1'b0, rnd_frame(), 1'b1, 1'b1);
        idle(1, 1'b1);
        chk("t4_cleared", 32'(drop_cnt), 0);

        // Strobe coinciding with the last-beat handshake, pending empty.
        step(1'b1, rnd_frame(), 1'b1, 1'b0);
        wait_q(1, "t5_reach_last");
        fc_before = mdl_fc;
        step(1'b1, rnd_frame(), 1'b1, 1'b0);
        chk("t5_valid", 32'(sif.m_valid), 1);
        chk("t5_chan0", 32'(sif.m_chan), 0);
        chk("t5_fcnt", 32'(frame_cnt), 32'((fc_before + 1) & 16'hFFFF));
        idle(6, 1'b1);

        // Reset on beat 2 of a frame.
        step(1'b1, rnd_frame(), 1'b1, 1'b0);
        wait_q(NCH - 2, "t6_reach_beat2");
        rst = 1'b1;
        #1;
        chk("t6_valid_now", 32'(sif.m_valid), 0);
        model_reset();
        @(negedge clk);
        step(1'b1, rnd_frame(), 1'b1, 1'b0);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step(1'b1, rnd_frame(), 1'b1, 1'b0);
            idle(6, 1'b1);
        end
        chk("t6_fcnt", 32'(frame_cnt), 1);

        // Random traffic with varying back-pressure.
        for (int b = 0; b < 8; b++) begin
            pct = $urandom_range(10, 100);
            for (int i = 0; i < 100; i++)
                step(1'($urandom_range(0, 5) == 0), rnd_frame(),
                     1'($urandom_range(0, 99) < pct), 1'($urandom_range(0, 39) == 0));
        end
        idle(40, 1'b1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pcm_frame_packer.md
Name: pcm_frame_packer

Overview:
- Sits directly downstream of the per-microphone CIC decimators.
- On each decimation strobe it snapshots the NCH parallel CIC outputs as one frame.
- It serialises each frame onto a single valid/ready stream, one channel per beat, for the beamforming and storage path.
- It discards start-up frames while the CIC combs settle, double-buffers one frame, and flags frames lost to back-pressure.

Parameters:
- NCH, 8, number of microphone channels per frame (2..16).
- W, 17, bit width of each CIC output sample (unsigned).
- SKIP_FRAMES, 3, number of initial strobes discarded after reset (0..15).

Ports:
- clk  in  1  system clock (CIC integrator clock domain).
- rst  in  1  reset, asynchronous, active-high.
- dec_stb  in  1  single-cycle decimation strobe, synchronous to clk.
- s_data  in  NCH*W  packed CIC outputs; channel k in bits [k*W +: W]; stable in the strobe cycle.
- m_data  out  W  sample for the current beat.
- m_chan  out  clog2(NCH)  channel index of the current beat.
- m_first  out  1  high on the channel-0 beat.
- m_last  out  1  high on the channel-(NCH-1) beat.
- m_valid  out  1  beat valid.
- m_ready  in  1  consumer accepts the beat.
- ovf  out  1  sticky: one or more frames dropped.
- ovf_clr  in  1  clears ovf and drop_cnt.
- drop_cnt  out  8  count of dropped frames, saturates at 255.
- frame_cnt  out  16  count of frames fully emitted, wraps.

Behaviour:
- Reset values: all outputs 0. Skip counter = SKIP_FRAMES. Active and pending buffers empty. FSM in IDLE.
- Skip phase:
  - While the skip counter is nonzero, each dec_stb decrements it and the frame is discarded.
  - No beats are emitted and ovf is not affected.
- FSM states are IDLE and SEND.
- IDLE, dec_stb with the skip phase done:
  - Capture s_data into the active buffer and set beat index = 0.
  - Next state SEND, with m_valid=1 in the next cycle. Latency from strobe to first beat is 1 clk.
- SEND:
  - m_data and m_chan are driven from the active buffer at the beat index, registered.
  - A beat transfers when m_valid && m_ready. The beat index increments on each transfer.
  - m_data, m_chan, m_first and m_last hold stable while m_valid=1 and m_ready=0.
- Last-beat transfer (index NCH-1):
  - frame_cnt increments.
  - If the pending buffer is full: move pending to active, index=0, stay in SEND. The next beat is presented the next cycle with no bubble.
  - Otherwise go to IDLE with m_valid=0.
- dec_stb during SEND:
  - If pending is empty, capture into pending.
  - If pending is full and not being drained this cycle, drop the new frame. Set ovf; drop_cnt increments (saturating).
- Simultaneous events:
  - dec_stb in the same cycle as a last-beat transfer with pending full: pending moves to active and the new frame is captured into pending. No drop.
  - dec_stb in the same cycle as a last-beat transfer with pending empty: the new frame becomes active directly, index=0, stay in SEND.
  - ovf_clr with a drop in the same cycle: set wins, ovf=1 and drop_cnt=1.
- Capture is a full-width register copy. Samples pass unmodified (no rounding or truncation).
- Reset mid-frame aborts the frame immediately: m_valid=0, both buffers are emptied, and the skip counter is reloaded.
- SKIP_FRAMES=0: the first strobe after reset is emitted.

Test Plan:
1. NCH=4, W=17, SKIP=3. s_data channels = 0x00011, 0x00022, 0x00033, 0x1FFFF. Apply 4 strobes with m_ready=1. Required: strobes 1–3 emit nothing. Strobe 4 gives beats chan 0..3 with those values on consecutive cycles, m_first on beat 0, m_last on beat 3, frame_cnt=1.
2. Back-pressure: hold m_ready=0 for 5 cycles mid-frame, then toggle it every other cycle. Required: output signals stay stable while stalled, no beat is duplicated or lost, and each transfer takes 2 cycles.
3. Double buffer: with m_ready=0, apply a 2nd strobe during frame A carrying data B. Then release m_ready. Required: the 4 beats of A are followed by the 4 beats of B with no idle cycle, and ovf=0.
4. Overflow: with m_ready=0, apply 3 strobes after the first. Required: frames 3 and 4 are dropped, ovf=1, drop_cnt=2. Pulse ovf_clr in the same cycle as a further drop: ovf=1, drop_cnt=1.
5. Coincidence: dec_stb in the same cycle as the last-beat handshake with pending empty. Required: the next cycle presents beat chan 0 of the new frame, no drop, and frame_cnt increments.
6. Assert rst during beat 2 of a frame, then release. Required: m_valid=0 immediately; the next 3 strobes are skipped and the 4th strobe is emitted.
